// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR datapath blocks.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } fir_state_e;

  localparam int FIR_NUM_TAPS = 10;
  localparam int FIR_DATA_W   = 3;
  localparam int FIR_COEFF_W  = 16;
  localparam int FIR_OUT_W    = 16;

  // Guard bits sized so that NUM_TAPS full-scale products can never overflow.
  function automatic int fir_acc_w(input int num_taps, input int data_w, input int coeff_w);
    return data_w + coeff_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and width reduction.
// FIR_MAC_SAT_EN selects clamping; otherwise the low OUT_W bits wrap.
module fir_round_sat #(
  parameter int ACC_W = 23,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

`ifdef FIR_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;

  // One extra bit so the rounding increment can never wrap the sum.
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  assign sum = {acc[ACC_W-1], acc} + RND;
  assign r   = sum >>> SHIFT;

  if (OUT_W > ACC_W) begin : g_wide
    assign res = OUT_W'(r);
    assign sat = 1'b0;
  end else begin : g_narrow
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    logic ovf;

    // Result fits only when every bit above the output sign bit matches it.
    assign ovf = (r[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){r[ACC_W]}});
    assign res = (SAT_EN && ovf) ? (r[ACC_W] ? OUT_MIN : OUT_MAX) : r[OUT_W-1:0];
    assign sat = SAT_EN && ovf;
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate: snapshots the delay chain on iStart, takes one
// coefficient per accepted cycle, then emits one rounded result. Option: FIR_MAC_SAT_EN.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int DATA_W   = FIR_DATA_W,
  parameter int COEFF_W  = FIR_COEFF_W,
  parameter int ACC_W    = fir_acc_w(NUM_TAPS, DATA_W, COEFF_W),
  parameter int OUT_W    = FIR_OUT_W,
  parameter int SHIFT    = 0
) (
  input  logic                          iClk12M,
  input  logic                          iRst,
  input  logic                          iStart,
  input  logic [NUM_TAPS*DATA_W-1:0]    iDelay,
  input  logic                          iCoeffValid,
  input  logic signed [COEFF_W-1:0]     iCoeff,
  output logic [$clog2(NUM_TAPS)-1:0]   oCoeffAddr,
  output logic                          oBusy,
  output logic                          oMacValid,
  output logic signed [OUT_W-1:0]       oMac,
  output logic                          oSat,
  output fir_state_e                    oDbgState
);

  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = COEFF_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAPS - 1);

  fir_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [NUM_TAPS*DATA_W-1:0]   snap_q, snap_d;
  logic signed [OUT_W-1:0]      mac_q, mac_d, mac_r;
  logic                         sat_q, sat_d, sat_r;
  logic                         valid_q, valid_d;
  logic signed [DATA_W-1:0]     taps [NUM_TAPS];
  logic signed [DATA_W-1:0]     tap_sel;
  logic signed [PROD_W-1:0]     prod;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
    assign taps[k] = snap_q[k*DATA_W +: DATA_W];
  end

  assign tap_sel = taps[idx_q];
  assign prod    = PROD_W'(iCoeff) * PROD_W'(tap_sel);

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc (acc_q),
    .res (mac_r),
    .sat (sat_r)
  );

  // Handshake: a coefficient is consumed on every rising edge in ACC where
  // iCoeffValid=1; iCoeff must then belong to oCoeffAddr. No backpressure is
  // given to the source, and iCoeffValid outside ACC is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    snap_d  = snap_q;
    mac_d   = mac_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          snap_d  = iDelay;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (iCoeffValid) begin
          acc_d = acc_q + ACC_W'(prod);
          if (idx_q == LAST) state_d = FIN;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      FIN: begin
        mac_d   = mac_r;
        sat_d   = sat_r;
        valid_d = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      mac_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      mac_q   <= mac_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign oCoeffAddr = idx_q;
  assign oBusy      = (state_q != IDLE);
  assign oMacValid  = valid_q;
  assign oMac       = mac_q;
  assign oSat       = sat_q;
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: vector table plus reset-abort, SHIFT=2 and held-start sequences.
module tb_fir_mac_seq;
  import fir_pkg::*;

  localparam int NT  = 10;
  localparam int DW  = 3;
  localparam int CW  = 16;
  localparam int OW  = 16;
  localparam int DLW = NT*DW;
  localparam int CLW = NT*CW;

  typedef struct packed {
    logic [DLW-1:0]        delay;
    logic [CLW-1:0]        coeffs;
    logic [1:0]            gap;
    logic signed [OW-1:0]  mac;
    logic                  sat;
  } vec_t;

  logic                 iClk12M = 1'b0;
  logic                 iRst;
  logic                 iStart, iStart2, iCoeffValid;
  logic [DLW-1:0]       iDelay;
  logic signed [CW-1:0] iCoeff;

  logic [3:0]           oCoeffAddr, oCoeffAddr2;
  logic                 oBusy, oBusy2, oMacValid, oMacValid2, oSat, oSat2;
  logic signed [OW-1:0] oMac, oMac2;
  fir_state_e           oDbgState, oDbgState2;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int start_edge;
  logic [OW:0] exp_q[$];
  logic [OW:0] exp2_q[$];
  int valid_edges[$];
  vec_t vecs[8];

  fir_mac_seq #(.NUM_TAPS(NT), .DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .SHIFT(0)) dut (
    .iClk12M(iClk12M), .iRst(iRst), .iStart(iStart), .iDelay(iDelay),
    .iCoeffValid(iCoeffValid), .iCoeff(iCoeff), .oCoeffAddr(oCoeffAddr),
    .oBusy(oBusy), .oMacValid(oMacValid), .oMac(oMac), .oSat(oSat),
    .oDbgState(oDbgState)
  );

  fir_mac_seq #(.NUM_TAPS(NT), .DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .SHIFT(2)) dut_sh2 (
    .iClk12M(iClk12M), .iRst(iRst), .iStart(iStart2), .iDelay(iDelay),
    .iCoeffValid(iCoeffValid), .iCoeff(iCoeff), .oCoeffAddr(oCoeffAddr2),
    .oBusy(oBusy2), .oMacValid(oMacValid2), .oMac(oMac2), .oSat(oSat2),
    .oDbgState(oDbgState2)
  );

  // Clock and edge counter
  always #5 iClk12M = ~iClk12M;
  always @(posedge iClk12M) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge iClk12M) begin : monitor
    logic [OW:0] e;
    if (oMacValid) begin
      valid_edges.push_back(edge_cnt);
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("mac", oMac, $signed(e[OW-1:0]));
        check("sat", oSat, e[OW]);
      end
    end
    if (oMacValid2) begin
      valid_edges.push_back(edge_cnt);
      if (exp2_q.size() == 0) check("unexpected_valid_sh2", 1, 0);
      else begin
        e = exp2_q.pop_front();
        check("mac_sh2", oMac2, $signed(e[OW-1:0]));
        check("sat_sh2", oSat2, e[OW]);
      end
    end
  end

  function automatic logic [DLW-1:0] fill_taps(input int v);
    logic [DLW-1:0] r;
    for (int k = 0; k < NT; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [CLW-1:0] ramp(input int base, input int step);
    logic [CLW-1:0] r;
    for (int k = 0; k < NT; k++) r[k*CW +: CW] = CW'(base + k*step);
    return r;
  endfunction

  // Driver tasks; inputs only change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic do_start(input bit sel, input logic [DLW-1:0] d);
    iDelay = d;
    if (sel) iStart2 = 1'b1;
    else     iStart  = 1'b1;
    tick();
    start_edge = edge_cnt;
    iStart  = 1'b0;
    iStart2 = 1'b0;
  endtask

  task automatic run_vec(input bit sel, input logic [DLW-1:0] d, input logic [CLW-1:0] c,
                         input int gap, input logic signed [OW-1:0] emac, input logic esat);
    int vb;
    if (sel) exp2_q.push_back({esat, emac});
    else     exp_q.push_back({esat, emac});
    vb = valid_edges.size();
    do_start(sel, d);
    check("busy_in_acc", sel ? oBusy2 : oBusy, 1);
    for (int k = 0; k < NT; k++) begin
      for (int g = 0; g < gap; g++) begin
        iCoeffValid = 1'b0;
        iCoeff = CW'($urandom);
        iDelay = DLW'($urandom);
        tick();
        check("addr_stall", sel ? oCoeffAddr2 : oCoeffAddr, k);
      end
      iCoeffValid = 1'b1;
      iCoeff = c[k*CW +: CW];
      check("addr", sel ? oCoeffAddr2 : oCoeffAddr, k);
      tick();
    end
    iCoeffValid = 1'b0;
    for (int t = 0; t < 20 && valid_edges.size() == vb; t++) tick();
    if (valid_edges.size() == vb) check("valid_timeout", 0, 1);
    else if (gap == 0) check("latency", valid_edges[$] - start_edge, NT + 1);
    check("idle_after", sel ? oBusy2 : oBusy, 0);
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    logic [DLW-1:0] d;
    logic [CLW-1:0] c;
    int mt[NT] = '{1, -1, 2, -2, 3, -3, -4, 0, 1, 2};
    int vb;

    vecs[0] = '{fill_taps(1),  ramp(1, 1),      2'd0, 16'sd55,  1'b0};
`ifdef FIR_MAC_SAT_EN
    vecs[1] = '{fill_taps(-4), ramp(1000, 0),   2'd0, -16'sd32768, 1'b1};
    vecs[4] = '{fill_taps(-4), ramp(-32768, 0), 2'd0, 16'sd32767,  1'b1};
    vecs[5] = '{fill_taps(3),  ramp(32767, 0),  2'd0, 16'sd32767,  1'b1};
`else
    vecs[1] = '{fill_taps(-4), ramp(1000, 0),   2'd0, 16'sd25536,  1'b0};
    vecs[4] = '{fill_taps(-4), ramp(-32768, 0), 2'd0, 16'sd0,      1'b0};
    vecs[5] = '{fill_taps(3),  ramp(32767, 0),  2'd0, -16'sd30,    1'b0};
`endif
    vecs[2] = '{fill_taps(1),  ramp(1, 1),      2'd1, 16'sd55,  1'b0};
    for (int k = 0; k < NT; k++) d[k*DW +: DW] = DW'(mt[k]);
    vecs[3] = '{d,             ramp(100, 100),  2'd2, -16'sd500, 1'b0};
    c = '0; c[0 +: CW] = 16'sd32767;
    vecs[6] = '{fill_taps(1),  c,               2'd0, 16'sd32767, 1'b0};
    c = '0; c[0 +: CW] = 16'sd8192;
    vecs[7] = '{fill_taps(-4), c,               2'd0, -16'sd32768, 1'b0};

    // Reset values
    iRst = 1'b1; iStart = 1'b0; iStart2 = 1'b0; iCoeffValid = 1'b0;
    iDelay = '0; iCoeff = '0;
    repeat (3) tick();
    check("rst_busy", oBusy, 0);
    check("rst_valid", oMacValid, 0);
    check("rst_mac", oMac, 0);
    check("rst_sat", oSat, 0);
    check("rst_addr", oCoeffAddr, 0);
    check("rst_state", oDbgState, IDLE);
    iRst = 1'b0;
    iCoeffValid = 1'b1;
    tick();
    check("idle_ignores_coeff", oCoeffAddr, 0);
    iCoeffValid = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++)
      run_vec(1'b0, vecs[i].delay, vecs[i].coeffs, int'(vecs[i].gap), vecs[i].mac, vecs[i].sat);

    // SHIFT=2 instance: 55 -> 14, -6 -> -1
    run_vec(1'b1, fill_taps(1), ramp(1, 1), 0, 16'sd14, 1'b0);
    d = fill_taps(1); d[0 +: DW] = 3'b110;
    c = '0; c[0 +: CW] = 16'sd3;
    run_vec(1'b1, d, c, 0, -16'sd1, 1'b0);

    // Reset abort mid-accumulation: outputs clear, no result pulse follows
    vb = valid_edges.size();
    do_start(1'b0, fill_taps(1));
    for (int k = 0; k < 6; k++) begin
      iCoeffValid = 1'b1; iCoeff = CW'(k + 1);
      tick();
    end
    check("abort_addr_before", oCoeffAddr, 6);
    #2 iRst = 1'b1;
    #1;
    check("abort_busy", oBusy, 0);
    check("abort_addr", oCoeffAddr, 0);
    check("abort_mac", oMac, 0);
    check("abort_sat", oSat, 0);
    check("abort_valid", oMacValid, 0);
    check("abort_state", oDbgState, IDLE);
    repeat (2) tick();
    iRst = 1'b0;
    repeat (15) tick();
    iCoeffValid = 1'b0;
    check("abort_no_valid", valid_edges.size() - vb, 0);
    run_vec(1'b0, fill_taps(1), ramp(1, 1), 0, 16'sd55, 1'b0);

    // iStart held high: back-to-back runs, each using its own snapshot
    exp_q.push_back({1'b0, 16'sd55});
    exp_q.push_back({1'b0, 16'sd110});
    vb = valid_edges.size();
    iDelay = fill_taps(1); iStart = 1'b1; iCoeffValid = 1'b1; iCoeff = 16'sd1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (e == 0)  iDelay = fill_taps(2);
      if (e == 12) iStart = 1'b0;
      iCoeff = CW'(oCoeffAddr + 1);
    end
    iCoeffValid = 1'b0;
    check("hold_count", valid_edges.size() - vb, 2);
    if (valid_edges.size() - vb == 2)
      check("hold_spacing", valid_edges[vb+1] - valid_edges[vb], NT + 2);

    check("exp_q_drained", exp_q.size() + exp2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
